lsu_mem_if: RTL and testbench
=============================

# lsu_mem_if

Load/store unit front-end sitting directly upstream of the byte-addressable data BRAM. Accepts one memory request at a time from the execute stage (RISC-V funct3 encoding), drives the BRAM write-enable, size-select, address and write-data ports, and returns the load result sign- or zero-extended to 32 bits. Handles the BRAM's one-cycle registered read latency with a small FSM and valid/ready handshake; flags illegal, out-of-window and (optionally) misaligned accesses.

## Interface
Parameters:
- ADDR_W, 10, BRAM byte-address width (1024 bytes)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data (0 for stores/errors)
- rsp_err  out  1  request rejected, valid with rsp_valid
- mem_wena  out  1  BRAM write enable
- mem_ba / mem_ha / mem_ua  out  1 each  byte / half / unsigned select
- mem_addr  out  ADDR_W  BRAM byte address
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM registered read data, bytes [addr+3..addr]

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset → IDLE.
- IDLE: req_ready=1. On req_valid&req_ready: latch we/funct3/addr/wdata, compute err, go ACCESS. Requests while not IDLE ignored; requester holds.
- ACCESS: mem_addr=latched addr[ADDR_W-1:0]; mem_ba=(size B), mem_ha=(size H), word → both 0; mem_ua=funct3[2]; mem_wdata=latched wdata; mem_wena = we & !err & !rst. Go RESP.
- RESP: rsp_valid=1, rsp_err=err. Load, no err: B → {{24{d[7]}},d[7:0]}, BU → {24'b0,d[7:0]}, H → {{16{d[15]}},d[15:0]}, HU → {16'b0,d[15:0]}, W → d, with d=mem_rdata. Store or err → rsp_rdata=0. Go IDLE.
- err conditions: funct3 in {011,110,111}; store with funct3 100/101; req_addr[31:ADDR_W]≠0; last byte (addr+size−1) > 2^ADDR_W−1 (no wrap-around permitted); misaligned per Configuration. Errored store never asserts mem_wena.
- Outside ACCESS/RESP: mem_wena=0, mem_addr/mem_wdata hold last latched values (keeps BRAM read stable), rsp_valid=0, rsp_rdata=0, rsp_err=0.

## Timing
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wena=0, mem_ba=mem_ha=mem_ua=0, mem_addr=0, mem_wdata=0.
- Accept at edge E0 → ACCESS in cycle after E0 → BRAM samples addr/wena at E1 → rsp_valid high in cycle after E1, sampled by consumer at E2. Fixed latency 2 cycles; throughput 1 request / 3 cycles.
- Store commits at E1; a load to the same bytes accepted afterwards returns new data.
- rst high in any cycle: next state IDLE, no response; rst during ACCESS suppresses the write (mem_wena gated combinationally).
- rsp has no backpressure; consumer must sample on the pulse.

## Configuration
- MISALIGN_TRAP_EN defined: H/HU with addr[0]≠0, or W with addr[1:0]≠0, sets err (store suppressed, rdata 0).
- Undefined: misaligned accesses proceed unmodified (BRAM is byte-addressed); only window-crossing check remains.

## Test plan
- SW 0xDEADBEEF @0x010, then LW @0x010 → rsp_rdata=0xDEADBEEF, err=0, rsp_valid exactly 2 cycles after each acceptance.
- After above: LB @0x013 → 0xFFFFFFDE; LBU @0x013 → 0x000000DE; LH @0x012 → 0xFFFFDEAD; LHU @0x010 → 0x0000BEEF.
- SH 0x1234 @0x011: with MISALIGN_TRAP_EN → err=1, LW @0x010 still 0xDEADBEEF; without → err=0, LW @0x010 = 0xDE1234EF.
- LW @0x3FE and req_addr=0x400 → err=1, rdata=0, no mem_wena; funct3=011 → err=1.
- Assert rst in ACCESS cycle of SW 0x55AA55AA @0x020 → no rsp_valid, mem_wena never 1; LW @0x020 returns prior contents.
- req_valid held high back-to-back → req_ready low in ACCESS/RESP, second request accepted only on return to IDLE.

Source files
------------

// File: rtl/lsu_mem_if.sv
// Load/store front-end for a byte-addressed BRAM with a one-cycle registered read.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module lsu_mem_if #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_wena,
    output logic              mem_ba,
    output logic              mem_ha,
    output logic              mem_ua,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, next_state;

    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;

    logic              accept;
    logic              req_err;
    logic [ADDR_W:0]   last_byte;
    logic [1:0]        size_m1;
    logic              bad_funct3;
    logic              misalign;

    assign accept = req_valid && (state == IDLE);

    // Request error classification, evaluated on the incoming request.
    always_comb begin
        size_m1 = 2'd0;
        case (req_funct3[1:0])
            2'b00:   size_m1 = 2'd0;
            2'b01:   size_m1 = 2'd1;
            default: size_m1 = 2'd3;
        endcase
        last_byte  = {1'b0, req_addr[ADDR_W-1:0]} + (ADDR_W+1)'(size_m1);
        bad_funct3 = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
`ifdef MISALIGN_TRAP_EN
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        req_err = bad_funct3 ||
                  (req_we && req_funct3[2]) ||
                  (req_addr[31:ADDR_W] != '0) ||
                  last_byte[ADDR_W] ||
                  misalign;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[ADDR_W-1:0];
            wdata_q  <= req_wdata;
            err_q    <= req_err;
        end
    end

    // Address and write data stay on the last latched values so the BRAM read is stable.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        req_ready = (state == IDLE);
        mem_wena  = 1'b0;
        mem_ba    = 1'b0;
        mem_ha    = 1'b0;
        mem_ua    = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        case (state)
            ACCESS: begin
                mem_ba   = (funct3_q[1:0] == 2'b00);
                mem_ha   = (funct3_q[1:0] == 2'b01);
                mem_ua   = funct3_q[2];
                mem_wena = we_q && !err_q && !rst;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (!we_q && !err_q) begin
                    case (funct3_q)
                        3'b000:  rsp_rdata = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
                        3'b100:  rsp_rdata = {24'b0, mem_rdata[7:0]};
                        3'b001:  rsp_rdata = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
                        3'b101:  rsp_rdata = {16'b0, mem_rdata[15:0]};
                        3'b010:  rsp_rdata = mem_rdata;
                        default: rsp_rdata = '0;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Scoreboard bench for lsu_mem_if: directed requests against a byte-addressed BRAM model.
module tb_lsu_mem_if;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_wena;
    logic              mem_ba;
    logic              mem_ha;
    logic              mem_ua;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    lsu_mem_if #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_wena(mem_wena), .mem_ba(mem_ba), .mem_ha(mem_ha), .mem_ua(mem_ua),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // BRAM model: byte array, size-selected writes, registered 4-byte read.
    logic [7:0] ram [0:(1<<ADDR_W)-1];
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        logic [ADDR_W-1:0] a;
        a = mem_addr;
        mem_rdata <= {ram[ADDR_W'(a + 3)], ram[ADDR_W'(a + 2)], ram[ADDR_W'(a + 1)], ram[a]};
        if (mem_wena) begin
            ram[a] <= mem_wdata[7:0];
            if (!mem_ba) ram[ADDR_W'(a + 1)] <= mem_wdata[15:8];
            if (!mem_ba && !mem_ha) begin
                ram[ADDR_W'(a + 2)] <= mem_wdata[23:16];
                ram[ADDR_W'(a + 3)] <= mem_wdata[31:24];
            end
        end
    end

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned wena_count = 0;
    int unsigned exp_wena = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int unsigned at_cyc;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        if (mem_wena) wena_count++;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_rdata"}, rsp_rdata, e.rdata);
                check({e.name, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
                check({e.name, "_latency"}, cyc, e.at_cyc);
            end
        end
    end

    // Issue one request; returns number of cycles spent waiting for req_ready.
    task automatic send(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input bit expect_rsp, input bit hold, output int unsigned waits);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        waits = 0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            check({name, "_ready_timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (expect_rsp) begin
            e.name = name; e.rdata = exp_rdata; e.err = exp_err;
            e.at_cyc = cyc + 2;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain;
        int unsigned g;
        g = 0;
        while (sb.size() != 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        int unsigned w;
        logic [31:0] sh_word;
        logic        sh_err;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_mem_wena", {31'b0, mem_wena}, 32'd0);
        check("rst_mem_sel", {29'b0, mem_ba, mem_ha, mem_ua}, 32'd0);
        check("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        send("sw_10", 1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0, 0, 1, 0, w); exp_wena++;
        send("lw_10", 0, 3'b010, 32'h010, 32'h0, 32'hDEADBEEF, 0, 1, 0, w);
        send("lb_13", 0, 3'b000, 32'h013, 32'h0, 32'hFFFFFFDE, 0, 1, 0, w);
        send("lbu_13", 0, 3'b100, 32'h013, 32'h0, 32'h000000DE, 0, 1, 0, w);
        send("lh_12", 0, 3'b001, 32'h012, 32'h0, 32'hFFFFDEAD, 0, 1, 0, w);
        send("lhu_10", 0, 3'b101, 32'h010, 32'h0, 32'h0000BEEF, 0, 1, 0, w);

`ifdef MISALIGN_TRAP_EN
        sh_err = 1'b1; sh_word = 32'hDEADBEEF;
`else
        sh_err = 1'b0; sh_word = 32'hDE1234EF; exp_wena++;
`endif
        send("sh_11", 1, 3'b001, 32'h011, 32'h00001234, 32'h0, sh_err, 1, 0, w);
        send("lw_10_after_sh", 0, 3'b010, 32'h010, 32'h0, sh_word, 0, 1, 0, w);

        send("lw_3fe", 0, 3'b010, 32'h3FE, 32'h0, 32'h0, 1, 1, 0, w);
        send("lw_400", 0, 3'b010, 32'h400, 32'h0, 32'h0, 1, 1, 0, w);
        send("f3_011", 0, 3'b011, 32'h010, 32'h0, 32'h0, 1, 1, 0, w);
        send("sw_3ff", 1, 3'b010, 32'h3FF, 32'hFFFFFFFF, 32'h0, 1, 1, 0, w);
        send("sbu_st", 1, 3'b100, 32'h010, 32'hFFFFFFFF, 32'h0, 1, 1, 0, w);
        send("lb_3ff", 0, 3'b000, 32'h3FF, 32'h0, 32'h0, 0, 1, 0, w);

        send("sw_20", 1, 3'b010, 32'h020, 32'h01020304, 32'h0, 0, 1, 0, w); exp_wena++;
        drain();

        // Reset asserted during the ACCESS cycle of a store: no response, no write.
        send("sw_20_rst", 1, 3'b010, 32'h020, 32'h55AA55AA, 32'h0, 0, 0, 0, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_abort_ready", {31'b0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        send("lw_20", 0, 3'b010, 32'h020, 32'h0, 32'h01020304, 0, 1, 0, w);

        // Back-to-back: second request must wait through ACCESS and RESP.
        send("b2b_a", 0, 3'b010, 32'h010, 32'h0, sh_word, 0, 1, 1, w);
        send("b2b_b", 0, 3'b100, 32'h010, 32'h0, 32'h000000EF, 0, 1, 0, w);
        check("b2b_wait_cycles", w, 32'd2);

        drain();
        repeat (3) @(negedge clk);
        check("wena_pulses", wena_count, exp_wena);
        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
